// File: rtl/lc3_decode_queue_if.sv
// Handshake bundle between fetch and execute around the LC-3 decode queue.
// master drives instructions and consumes decoded entries; slave is the queue.
interface lc3_decode_queue_if #(
    parameter int IW    = 16,
    parameter int PCW   = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [IW-1:0]  in_ir;
    logic [PCW-1:0] in_npc;
    logic           out_valid;
    logic           out_ready;
    logic [IW-1:0]  out_ir;
    logic [PCW-1:0] out_npc;
    logic [5:0]     out_e_control;
    logic [1:0]     out_w_control;
    logic           out_illegal;
    logic [CW-1:0]  count;

    modport master (
        output flush, in_valid, in_ir, in_npc, out_ready,
        input  in_ready, out_valid, out_ir, out_npc,
        input  out_e_control, out_w_control, out_illegal, count
    );

    modport slave (
        input  flush, in_valid, in_ir, in_npc, out_ready,
        output in_ready, out_valid, out_ir, out_npc,
        output out_e_control, out_w_control, out_illegal, count
    );
endinterface

// File: rtl/lc3_decode_queue.sv
// LC-3 decode queue: decodes on push, holds DEPTH decoded entries in a FIFO.
// Define LC3_DECODE_ILLEGAL_EN to store and report the unsupported-opcode flag.
module lc3_decode_queue #(
    parameter int IW    = 16,
    parameter int PCW   = 16,
    parameter int DEPTH = 4
) (
    input logic              clock,
    input logic              reset,
    lc3_decode_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [IW-1:0]  ir;
        logic [PCW-1:0] npc;
        logic [5:0]     e_ctl;
        logic [1:0]     w_ctl;
`ifdef LC3_DECODE_ILLEGAL_EN
        logic           illegal;
`endif
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    entry_t     ent;
    entry_t     head;
    logic [3:0] op;
    logic       out_valid;
    logic       in_ready;
    logic       push;
    logic       pop;

    always_comb begin
        op        = q.in_ir[15:12];
        ent       = '0;
        ent.ir    = q.in_ir;
        ent.npc   = q.in_npc;
`ifdef LC3_DECODE_ILLEGAL_EN
        ent.illegal = 1'b0;
`endif
        case (op)
            4'b0001: ent.e_ctl = {5'b00000, ~q.in_ir[5]};
            4'b0101: ent.e_ctl = {5'b01000, ~q.in_ir[5]};
            4'b1001: ent.e_ctl = 6'b100000;
            4'b1110: begin
                ent.e_ctl = 6'b000110;
                ent.w_ctl = 2'b10;
            end
            4'b0010, 4'b1010: begin
                ent.e_ctl = 6'b000110;
                ent.w_ctl = 2'b01;
            end
            4'b0110: begin
                ent.e_ctl = 6'b001000;
                ent.w_ctl = 2'b01;
            end
            default: begin
`ifdef LC3_DECODE_ILLEGAL_EN
                ent.illegal = 1'b1;
`endif
            end
        endcase
    end

    // reset gates in_ready so nothing is accepted on the reset edge
    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q < CW'(DEPTH)) & ~q.flush & ~reset;
    assign push      = q.in_valid & in_ready;
    assign pop       = out_valid & q.out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = ent;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // payload storage needs no reset: outputs are masked while empty
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head = out_valid ? mem_q[rd_ptr_q] : '0;
    end

    assign q.in_ready      = in_ready;
    assign q.out_valid     = out_valid;
    assign q.out_ir        = head.ir;
    assign q.out_npc       = head.npc;
    assign q.out_e_control = head.e_ctl;
    assign q.out_w_control = head.w_ctl;
    assign q.count         = count_q;
`ifdef LC3_DECODE_ILLEGAL_EN
    assign q.out_illegal   = head.illegal;
`else
    assign q.out_illegal   = 1'b0;
`endif
endmodule

// File: tb/tb_lc3_decode_queue.sv
// Directed testbench for lc3_decode_queue (DEPTH=4).
// Illegal-flag expectations follow LC3_DECODE_ILLEGAL_EN.
module tb_lc3_decode_queue;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    lc3_decode_queue_if #(.IW(16), .PCW(16), .DEPTH(4)) bus ();

    lc3_decode_queue #(.IW(16), .PCW(16), .DEPTH(4)) dut (
        .clock (clk),
        .reset (rst),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LC3_DECODE_ILLEGAL_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ir     = 16'h0;
        bus.in_npc    = 16'h0;
        bus.out_ready = 1'b0;
    endtask

    task automatic push1(input logic [15:0] ir, input logic [15:0] npc);
        bus.in_valid = 1'b1;
        bus.in_ir    = ir;
        bus.in_npc   = npc;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop1();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready_during got %b want 0", bus.in_ready);
        end
        checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_state got count=%0d valid=%b want 0/0",
                     bus.count, bus.out_valid);
        end
        checks++;
        if (bus.out_ir !== 16'h0 || bus.out_npc !== 16'h0 ||
            bus.out_e_control !== 6'd0 || bus.out_w_control !== 2'd0 ||
            bus.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_zero got ir=%h npc=%h e=%b w=%b il=%b want zeros",
                     bus.out_ir, bus.out_npc, bus.out_e_control,
                     bus.out_w_control, bus.out_illegal);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready_after got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_add();
        push1(16'h1042, 16'h3001);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.count !== 3'd1) begin
            errors++;
            $display("FAIL add_valid got valid=%b count=%0d want 1/1",
                     bus.out_valid, bus.count);
        end
        checks++;
        if (bus.out_e_control !== 6'b000001 || bus.out_w_control !== 2'b00 ||
            bus.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL add_ctrl got e=%b w=%b il=%b want 000001/00/0",
                     bus.out_e_control, bus.out_w_control, bus.out_illegal);
        end
        checks++;
        if (bus.out_ir !== 16'h1042 || bus.out_npc !== 16'h3001) begin
            errors++;
            $display("FAIL add_data got ir=%h npc=%h want 1042/3001",
                     bus.out_ir, bus.out_npc);
        end
        pop1();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ir !== 16'h0 ||
            bus.out_e_control !== 6'd0) begin
            errors++;
            $display("FAIL add_empty got valid=%b ir=%h e=%b want 0/0000/000000",
                     bus.out_valid, bus.out_ir, bus.out_e_control);
        end
        pop1();
        checks++;
        if (bus.count !== 3'd0) begin
            errors++;
            $display("FAIL pop_empty got count=%0d want 0", bus.count);
        end
    endtask

    task automatic test_decode_order();
        logic [15:0] irs [3];
        logic [5:0]  es  [3];
        logic [1:0]  ws  [3];
        irs = '{16'h5262, 16'h967F, 16'hE005};
        es  = '{6'b010000, 6'b100000, 6'b000110};
        ws  = '{2'b00, 2'b00, 2'b10};
        for (int i = 0; i < 3; i++) push1(irs[i], 16'h3100 + 16'(i));
        checks++;
        if (bus.count !== 3'd3) begin
            errors++;
            $display("FAIL order_count got %0d want 3", bus.count);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_ir !== irs[i] || bus.out_e_control !== es[i] ||
                bus.out_w_control !== ws[i] ||
                bus.out_npc !== 16'h3100 + 16'(i)) begin
                errors++;
                $display("FAIL order_%0d got ir=%h e=%b w=%b npc=%h want %h/%b/%b/%h",
                         i, bus.out_ir, bus.out_e_control, bus.out_w_control,
                         bus.out_npc, irs[i], es[i], ws[i], 16'h3100 + 16'(i));
            end
            pop1();
        end
    endtask

    task automatic test_load_ops();
        logic [15:0] irs [4];
        logic [5:0]  es  [4];
        logic [1:0]  ws  [4];
        irs = '{16'h2205, 16'h6442, 16'hA603, 16'h1060};
        es  = '{6'b000110, 6'b001000, 6'b000110, 6'b000000};
        ws  = '{2'b01, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            push1(irs[i], 16'h3200);
            checks++;
            if (bus.out_e_control !== es[i] || bus.out_w_control !== ws[i] ||
                bus.out_illegal !== 1'b0) begin
                errors++;
                $display("FAIL load_%0d got e=%b w=%b il=%b want %b/%b/0",
                         i, bus.out_e_control, bus.out_w_control,
                         bus.out_illegal, es[i], ws[i]);
            end
            pop1();
        end
    endtask

    task automatic test_full_wrap();
        logic [15:0] exp_ir [4];
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_ir    = 16'h1000 + 16'(i);
            bus.in_npc   = 16'h4000 + 16'(i);
            #1;
            checks++;
            if (bus.in_ready !== (i < 4)) begin
                errors++;
                $display("FAIL full_ready_%0d got %b want %b",
                         i, bus.in_ready, (i < 4));
            end
            step();
        end
        checks++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0 ||
            bus.out_ir !== 16'h1000) begin
            errors++;
            $display("FAIL full_state got count=%0d rdy=%b head=%h want 4/0/1000",
                     bus.count, bus.in_ready, bus.out_ir);
        end
        // pop at full while offering: push must be refused
        bus.in_ir     = 16'h1005;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.count !== 3'd3 || bus.out_ir !== 16'h1001) begin
            errors++;
            $display("FAIL full_pop got count=%0d head=%h want 3/1001",
                     bus.count, bus.out_ir);
        end
        bus.in_ir  = 16'h1006;
        bus.in_npc = 16'h4006;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.count !== 3'd3) begin
            errors++;
            $display("FAIL pushpop_count got %0d want 3", bus.count);
        end
        exp_ir = '{16'h1002, 16'h1003, 16'h1006, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_ir !== exp_ir[i] || bus.out_valid !== (i < 3)) begin
                errors++;
                $display("FAIL wrap_%0d got ir=%h valid=%b want %h/%b",
                         i, bus.out_ir, bus.out_valid, exp_ir[i], (i < 3));
            end
            pop1();
        end
    endtask

    task automatic test_flush();
        push1(16'h1042, 16'h5000);
        push1(16'h5262, 16'h5001);
        push1(16'h967F, 16'h5002);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_ir    = 16'hE005;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %b want 0", bus.in_ready);
        end
        step();
        idle();
        checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 ||
            bus.out_ir !== 16'h0) begin
            errors++;
            $display("FAIL flush_state got count=%0d valid=%b ir=%h want 0/0/0000",
                     bus.count, bus.out_valid, bus.out_ir);
        end
        step();
        checks++;
        if (bus.count !== 3'd0) begin
            errors++;
            $display("FAIL flush_drop got count=%0d want 0", bus.count);
        end
    endtask

    task automatic test_illegal();
        push1(16'hD000, 16'h6000);
        checks++;
        if (bus.out_illegal !== ILL_EXP || bus.out_e_control !== 6'd0 ||
            bus.out_w_control !== 2'd0 || bus.out_ir !== 16'hD000) begin
            errors++;
            $display("FAIL illegal got il=%b e=%b w=%b ir=%h want %b/000000/00/d000",
                     bus.out_illegal, bus.out_e_control, bus.out_w_control,
                     bus.out_ir, ILL_EXP);
        end
        pop1();
    endtask

    task automatic test_reset_midstream();
        push1(16'h1042, 16'h7000);
        push1(16'h2205, 16'h7001);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state got count=%0d valid=%b rdy=%b want 0/0/1",
                     bus.count, bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.out_ir !== 16'h0 || bus.out_npc !== 16'h0 ||
            bus.out_e_control !== 6'd0 || bus.out_w_control !== 2'd0 ||
            bus.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL midrst_out got ir=%h npc=%h e=%b w=%b il=%b want zeros",
                     bus.out_ir, bus.out_npc, bus.out_e_control,
                     bus.out_w_control, bus.out_illegal);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_add();
        test_decode_order();
        test_load_ops();
        test_full_wrap();
        test_flush();
        test_illegal();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
